// File: rtl/convolutor_param.sv
// Linear convolution coprocessor: Z[k] = sum_j X[j]*Y[k-j] over runtime sizes, external sync RAMs.
// Optional macro CONVOLUTOR_SAT_EN saturates dataZ to the output width instead of wrapping.
module convolutor_param #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned ACC_WIDTH  = 2 * DATA_WIDTH + ADDR_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    signed_i,
    input  logic [ADDR_WIDTH-1:0]   sizeX,
    input  logic [ADDR_WIDTH-1:0]   sizeY,
    output logic [ADDR_WIDTH-1:0]   memX_addr,
    input  logic [DATA_WIDTH-1:0]   dataX,
    output logic [ADDR_WIDTH-1:0]   memY_addr,
    input  logic [DATA_WIDTH-1:0]   dataY,
    output logic [ADDR_WIDTH:0]     memZ_addr,
    output logic [2*DATA_WIDTH-1:0] dataZ,
    output logic                    writeZ,
    output logic                    busy,
    output logic                    done
);
    localparam int unsigned KW = ADDR_WIDTH + 1;
    localparam int unsigned ZW = 2 * DATA_WIDTH;
    localparam int unsigned EW = ACC_WIDTH - DATA_WIDTH;
    localparam logic [KW-1:0] KOne = KW'(1);
    localparam logic [KW-1:0] KTwo = KW'(2);
    localparam logic [ADDR_WIDTH-1:0] AOne = ADDR_WIDTH'(1);

    typedef enum logic [2:0] {StIdle, StSetk, StRd, StMac, StWr, StDone} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] n_q, n_d, m_q, m_d;
    logic                  sgn_q, sgn_d;
    logic [KW-1:0]         k_q, k_d;
    logic [ADDR_WIDTH-1:0] j_q, j_d, jhi_q, jhi_d;
    logic [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [ADDR_WIDTH-1:0] addr_x_q, addr_x_d, addr_y_q, addr_y_d;
    logic [KW-1:0]         z_addr_q, z_addr_d;
    logic [ZW-1:0]         z_data_q, z_data_d;

    logic [ACC_WIDTH-1:0]  ext_x, ext_y, prod;
    logic [KW-1:0]         n_ext, m_ext, k_last;
    logic [ZW-1:0]         z_val;

    always_comb begin
        ext_x  = {{EW{sgn_q & dataX[DATA_WIDTH-1]}}, dataX};
        ext_y  = {{EW{sgn_q & dataY[DATA_WIDTH-1]}}, dataY};
        // Low ACC_WIDTH bits of the product are correct for both signed and unsigned operands.
        prod   = ext_x * ext_y;
        n_ext  = {1'b0, n_q};
        m_ext  = {1'b0, m_q};
        k_last = n_ext + m_ext - KTwo;
    end

`ifdef CONVOLUTOR_SAT_EN
    always_comb begin
        z_val = acc_q[ZW-1:0];
        if (sgn_q) begin
            if (!((&acc_q[ACC_WIDTH-1:ZW-1]) || !(|acc_q[ACC_WIDTH-1:ZW-1]))) begin
                z_val = acc_q[ACC_WIDTH-1] ? {1'b1, {(ZW-1){1'b0}}} : {1'b0, {(ZW-1){1'b1}}};
            end
        end else if (|acc_q[ACC_WIDTH-1:ZW]) begin
            z_val = {ZW{1'b1}};
        end
    end
`else
    always_comb begin
        z_val = acc_q[ZW-1:0];
    end
`endif

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        m_d      = m_q;
        sgn_d    = sgn_q;
        k_d      = k_q;
        j_d      = j_q;
        jhi_d    = jhi_q;
        acc_d    = acc_q;
        addr_x_d = addr_x_q;
        addr_y_d = addr_y_q;
        z_addr_d = z_addr_q;
        z_data_d = z_data_q;
        writeZ   = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    n_d   = sizeX;
                    m_d   = sizeY;
                    sgn_d = signed_i;
                    k_d   = '0;
                    if (sizeX == '0 || sizeY == '0) begin
                        state_d = StDone;
                    end else begin
                        state_d = StSetk;
                    end
                end
            end
            StSetk: begin
                busy  = 1'b1;
                acc_d = '0;
                j_d   = (k_q >= m_ext) ? ADDR_WIDTH'(k_q - m_ext + KOne) : '0;
                jhi_d = (k_q < n_ext) ? ADDR_WIDTH'(k_q) : n_q - AOne;
                state_d = StRd;
            end
            StRd: begin
                busy     = 1'b1;
                addr_x_d = j_q;
                addr_y_d = ADDR_WIDTH'(k_q - {1'b0, j_q});
                state_d  = StMac;
            end
            StMac: begin
                busy  = 1'b1;
                acc_d = acc_q + prod;
                if (j_q < jhi_q) begin
                    // Next address goes out now so its data lines up with the next MAC cycle.
                    j_d      = j_q + AOne;
                    addr_x_d = j_q + AOne;
                    addr_y_d = ADDR_WIDTH'(k_q - {1'b0, j_q} - KOne);
                end else begin
                    state_d = StWr;
                end
            end
            StWr: begin
                busy     = 1'b1;
                writeZ   = 1'b1;
                z_addr_d = k_q;
                z_data_d = z_val;
                if (k_q == k_last) begin
                    state_d = StDone;
                end else begin
                    k_d     = k_q + KOne;
                    state_d = StSetk;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        memX_addr = addr_x_d;
        memY_addr = addr_y_d;
        memZ_addr = z_addr_d;
        dataZ     = z_data_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            n_q      <= '0;
            m_q      <= '0;
            sgn_q    <= 1'b0;
            k_q      <= '0;
            j_q      <= '0;
            jhi_q    <= '0;
            acc_q    <= '0;
            addr_x_q <= '0;
            addr_y_q <= '0;
            z_addr_q <= '0;
            z_data_q <= '0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            m_q      <= m_d;
            sgn_q    <= sgn_d;
            k_q      <= k_d;
            j_q      <= j_d;
            jhi_q    <= jhi_d;
            acc_q    <= acc_d;
            addr_x_q <= addr_x_d;
            addr_y_q <= addr_y_d;
            z_addr_q <= z_addr_d;
            z_data_q <= z_data_d;
        end
    end

endmodule

// File: tb/tb_convolutor_param.sv
// Directed bench for convolutor_param with behavioural sync-read X/Y RAMs and a Z write monitor.
module tb_convolutor_param;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        signed_i;
    logic [4:0]  sizeX, sizeY;
    logic [4:0]  memX_addr, memY_addr;
    logic [7:0]  dataX, dataY;
    logic [5:0]  memZ_addr;
    logic [15:0] dataZ;
    logic        writeZ, busy, done;

    logic [7:0]  xmem [32];
    logic [7:0]  ymem [32];
    int          zq_addr [$];
    logic [15:0] zq_data [$];
    int          busy_cnt, done_cnt, done_delay;
    int          total = 0;
    int          bad = 0;

    convolutor_param dut (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_i(signed_i),
        .sizeX(sizeX), .sizeY(sizeY),
        .memX_addr(memX_addr), .dataX(dataX),
        .memY_addr(memY_addr), .dataY(dataY),
        .memZ_addr(memZ_addr), .dataZ(dataZ), .writeZ(writeZ),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        dataX <= xmem[memX_addr];
        dataY <= ymem[memY_addr];
    end

    always @(negedge clk) begin
        if (writeZ === 1'b1) begin
            zq_addr.push_back(int'(memZ_addr));
            zq_data.push_back(dataZ);
        end
        if (busy === 1'b1) busy_cnt++;
        if (done === 1'b1) done_cnt++;
    end

    task automatic clear_mon();
        zq_addr.delete();
        zq_data.delete();
        busy_cnt = 0;
        done_cnt = 0;
        done_delay = -1;
    endtask

    task automatic run(input int n, input int m, input bit sgn, input bit hold);
        time t0;
        bit  got;
        @(negedge clk);
        clear_mon();
        sizeX = 5'(n);
        sizeY = 5'(m);
        signed_i = sgn;
        start = 1'b1;
        t0 = $time;
        got = 1'b0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            if (done === 1'b1) begin
                got = 1'b1;
                done_delay = int'(($time - t0) / 10);
            end
        end
        start = 1'b0;
        if (!got) begin
            total++;
            bad++;
            $display("FAIL run_timeout: done not seen, n=%0d m=%0d", n, m);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        signed_i = 1'b0;
        sizeX = '0;
        sizeY = '0;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (writeZ !== 1'b0) begin bad++; $display("FAIL reset_writeZ: got %b want 0", writeZ); end
        total++; if (memX_addr !== '0 || memY_addr !== '0) begin
            bad++; $display("FAIL reset_xy_addr: got %0d/%0d want 0/0", memX_addr, memY_addr);
        end
        total++; if (memZ_addr !== '0 || dataZ !== '0) begin
            bad++; $display("FAIL reset_z: got %0d/%h want 0/0000", memZ_addr, dataZ);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_basic(input string tag);
        logic [15:0] exp_z [9] = '{16'd1, 16'd3, 16'd6, 16'd10, 16'd15, 16'd14, 16'd12, 16'd9, 16'd5};
        total++; if (zq_data.size() != 9) begin
            bad++; $display("FAIL %s_count: got %0d writes want 9", tag, zq_data.size());
        end
        for (int i = 0; i < 9 && i < zq_data.size(); i++) begin
            total++; if (zq_addr[i] != i || zq_data[i] !== exp_z[i]) begin
                bad++; $display("FAIL %s_z%0d: got addr %0d data %h want addr %0d data %h",
                                tag, i, zq_addr[i], zq_data[i], i, exp_z[i]);
            end
        end
        total++; if (busy_cnt != 52) begin bad++; $display("FAIL %s_busy: got %0d want 52", tag, busy_cnt); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL %s_done: got %0d want 1", tag, done_cnt); end
    endtask

    task automatic test_basic();
        for (int i = 0; i < 5; i++) begin
            xmem[i] = 8'(i + 1);
            ymem[i] = 8'd1;
        end
        run(5, 5, 1'b0, 1'b0);
        check_basic("basic");
    endtask

    task automatic test_signed();
        logic [15:0] exp_s [3] = '{16'hFFFD, 16'h000A, 16'hFFF8};
        logic [15:0] exp_u [3] = '{16'h02FD, 16'hFB0A, 16'h01F8};
        xmem[0] = 8'hFF; xmem[1] = 8'h02;
        ymem[0] = 8'h03; ymem[1] = 8'hFC;
        run(2, 2, 1'b1, 1'b0);
        total++; if (zq_data.size() != 3) begin bad++; $display("FAIL signed_count: got %0d want 3", zq_data.size()); end
        for (int i = 0; i < 3 && i < zq_data.size(); i++) begin
            total++; if (zq_data[i] !== exp_s[i]) begin
                bad++; $display("FAIL signed_z%0d: got %h want %h", i, zq_data[i], exp_s[i]);
            end
        end
        run(2, 2, 1'b0, 1'b0);
        total++; if (zq_data.size() != 3) begin bad++; $display("FAIL unsigned_count: got %0d want 3", zq_data.size()); end
        for (int i = 0; i < 3 && i < zq_data.size(); i++) begin
            total++; if (zq_data[i] !== exp_u[i]) begin
                bad++; $display("FAIL unsigned_z%0d: got %h want %h", i, zq_data[i], exp_u[i]);
            end
        end
    endtask

    task automatic test_overflow();
`ifdef CONVOLUTOR_SAT_EN
        logic [15:0] exp_z [3] = '{16'hFE01, 16'hFFFF, 16'hFE01};
`else
        logic [15:0] exp_z [3] = '{16'hFE01, 16'hFC02, 16'hFE01};
`endif
        xmem[0] = 8'hFF; xmem[1] = 8'hFF;
        ymem[0] = 8'hFF; ymem[1] = 8'hFF;
        run(2, 2, 1'b0, 1'b0);
        for (int i = 0; i < 3 && i < zq_data.size(); i++) begin
            total++; if (zq_data[i] !== exp_z[i]) begin
                bad++; $display("FAIL overflow_z%0d: got %h want %h", i, zq_data[i], exp_z[i]);
            end
        end
        total++; if (zq_data.size() != 3) begin bad++; $display("FAIL overflow_count: got %0d want 3", zq_data.size()); end
    endtask

    task automatic test_asym();
        logic [15:0] exp_z [3] = '{16'd6, 16'd8, 16'd10};
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 0) begin
                xmem[0] = 8'd2; ymem[0] = 8'd3; ymem[1] = 8'd4; ymem[2] = 8'd5;
                run(1, 3, 1'b0, 1'b0);
            end else begin
                ymem[0] = 8'd2; xmem[0] = 8'd3; xmem[1] = 8'd4; xmem[2] = 8'd5;
                run(3, 1, 1'b0, 1'b0);
            end
            total++; if (zq_data.size() != 3) begin
                bad++; $display("FAIL asym%0d_count: got %0d want 3", pass, zq_data.size());
            end
            for (int i = 0; i < 3 && i < zq_data.size(); i++) begin
                total++; if (zq_addr[i] != i || zq_data[i] !== exp_z[i]) begin
                    bad++; $display("FAIL asym%0d_z%0d: got addr %0d data %h want addr %0d data %h",
                                    pass, i, zq_addr[i], zq_data[i], i, exp_z[i]);
                end
            end
            total++; if (busy_cnt != 12) begin bad++; $display("FAIL asym%0d_busy: got %0d want 12", pass, busy_cnt); end
        end
    endtask

    task automatic test_zero_and_hold();
        run(0, 4, 1'b0, 1'b0);
        total++; if (zq_data.size() != 0) begin bad++; $display("FAIL zero_writes: got %0d want 0", zq_data.size()); end
        total++; if (busy_cnt != 0) begin bad++; $display("FAIL zero_busy: got %0d want 0", busy_cnt); end
        total++; if (done_delay != 1) begin bad++; $display("FAIL zero_done_delay: got %0d want 1", done_delay); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL zero_done_cnt: got %0d want 1", done_cnt); end
        xmem[0] = 8'd2; ymem[0] = 8'd3; ymem[1] = 8'd4; ymem[2] = 8'd5;
        run(1, 3, 1'b0, 1'b1);
        total++; if (zq_data.size() != 3 || done_cnt != 1 || busy_cnt != 12) begin
            bad++; $display("FAIL hold_start: got writes %0d done %0d busy %0d want 3 1 12",
                            zq_data.size(), done_cnt, busy_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int n_before;
        for (int i = 0; i < 5; i++) begin
            xmem[i] = 8'(i + 1);
            ymem[i] = 8'd1;
        end
        @(negedge clk);
        clear_mon();
        sizeX = 5'd5; sizeY = 5'd5; signed_i = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL midrst_pre_busy: got %b want 1", busy); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || writeZ !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL midrst_ctrl: got busy %b writeZ %b done %b want 0 0 0", busy, writeZ, done);
        end
        total++; if (memX_addr !== '0 || memY_addr !== '0 || memZ_addr !== '0 || dataZ !== '0) begin
            bad++; $display("FAIL midrst_outs: got %0d %0d %0d %h want all 0",
                            memX_addr, memY_addr, memZ_addr, dataZ);
        end
        n_before = zq_data.size();
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        total++; if (zq_data.size() != n_before) begin
            bad++; $display("FAIL midrst_nowrite: got %0d writes want %0d", zq_data.size(), n_before);
        end
        run(5, 5, 1'b0, 1'b0);
        check_basic("restart");
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            xmem[i] = '0;
            ymem[i] = '0;
        end
        clear_mon();
        test_reset();
        test_basic();
        test_signed();
        test_overflow();
        test_asym();
        test_zero_and_hold();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
